booth_sequencer: RTL
====================

// Module: booth_sequencer
// PURPOSE
// Control unit for radix-2 Booth multiplication; drives the load/shift controls of the
// A, Q, M shift registers and the adder inside the ALU datapath. Consumes Q[0] and Q[-1]
// and issues clear/load/add/sub/shift commands. Handshake is start/done, then the
// product goes out on the outbus in two beats (A then Q).
// PARAMETERS
// WIDTH  8  operand width in bits; the number of Booth iterations
// CNT_W  4  iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// clk      in   1      system clock, rising edge
// reset    in   1      asynchronous, active-low; 0 forces IDLE
// start    in   1      begin a multiply; sampled only in IDLE
// q0       in   1      Q register bit 0
// q_m1     in   1      Q[-1] extension flip-flop
// busy     out  1      high in every state except IDLE
// load_m   out  1      load M from inbus
// load_q   out  1      load Q from inbus
// clr_a    out  1      load A with zero and clear Q[-1]
// load_a   out  1      load A from the adder output
// add_sub  out  1      adder operation: 0 = A+M, 1 = A-M
// shift_r  out  1      arithmetic right shift of A:Q:Q[-1] as one chain
// out_sel  out  2      outbus source: 00 none, 01 A, 10 Q
// done     out  1      one-cycle pulse when the product has been output
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, cnt=0, every output 0.
// - States: IDLE -> LOAD -> {ADD -> SHIFT} x WIDTH -> OUT_A -> OUT_Q -> DONE -> IDLE.
// - IDLE: waits for start=1. start is ignored in all other states (no restart, no queueing).
// - LOAD (1 cycle): load_m=load_q=clr_a=1. cnt<=0.
// - ADD (1 cycle, always taken, so latency is fixed). Decode of {q0,q_m1}:
//   - 10: load_a=1, add_sub=1
//   - 01: load_a=1, add_sub=0
//   - 00 or 11: load_a=0, add_sub=0
//   - This decode is combinational from the inputs. All other outputs are Moore decodes of state.
// - SHIFT (1 cycle): shift_r=1. If cnt==WIDTH-1, go to OUT_A; else cnt<=cnt+1 and go to ADD.
// - OUT_A: out_sel=01. OUT_Q: out_sel=10. DONE: done=1, busy=1, then IDLE.
// - Latency: start sampled at edge N -> done high during cycle N+2*WIDTH+4
//   (20 cycles for WIDTH=8). busy is high from cycle N+1 through the DONE cycle.
// - Mutual exclusion: at most one of {load_a, shift_r, clr_a} is high in any cycle.
//   This keeps shift and load from colliding in the register mux selectors.
// - Reset mid-operation: returns to IDLE immediately and all outputs drop to 0 without
//   waiting for a clock edge. No done pulse is issued for the aborted operation.
// - start held high through DONE: the next operation begins with LOAD one cycle after
//   IDLE is re-entered, because start is sampled in IDLE.
// - Unused state encodings: next state is IDLE.
// STRUCTURE
// - Shared package alu_ctrl_pkg holds:
//   - state encoding localparams (3 bits: IDLE, LOAD, ADD, SHIFT, OUT_A, OUT_Q, DONE)
//   - out_sel codes (OUTSEL_NONE/A/Q)
//   - add_sub codes (OP_ADD, OP_SUB)
// - Sub-module iter_counter #(CNT_W) provides the iteration count.
//   - Ports: clk, reset (active-low), clr, inc, count, term.
//   - term = (count==WIDTH-1).
//   - Built from the team dff cells.
// - The FSM is a state register plus next-state and output decode in this module.
// TESTING (WIDTH=8)
// 1. Reset: hold reset=0 with start=1 -> all outputs 0, busy=0; release -> still IDLE until a clock edge samples start.
// 2. Latency: start pulse at edge 0 -> LOAD controls high in cycle 1; 8 shift_r pulses in
//    cycles 3,5,..,17; out_sel=01 in cycle 18, 10 in cycle 19; done=1 only in cycle 20.
// 3. Booth decode in ADD: {q0,q_m1}=10 -> load_a=1, add_sub=1; 01 -> load_a=1, add_sub=0;
//    00/11 -> load_a=0. With a datapath model, 7 x -3 -> A:Q = 16'hFFEB (-21).
// 4. Busy start: start pulsed again at cycle 6 -> ignored; exactly one done pulse, at cycle 20.
// 5. Reset abort: reset=0 at cycle 9 (mid-SHIFT) -> outputs 0 within the same cycle; no done
//    pulse; a fresh start afterwards gives a full 20-cycle run.
// 6. Edge operands: -128 x -128 -> 16'h4000; 0 x 127 -> 0; a checker asserts load_a/shift_r/clr_a never overlap.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control path: FSM states, outbus select codes
// and adder operation codes.
package alu_ctrl_pkg;

    // Seven states fit in three bits; encoding 3'd7 is unused and recovers to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_OUT_A = 3'd4,
        ST_OUT_Q = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] OUTSEL_NONE = 2'b00;
    localparam logic [1:0] OUTSEL_A    = 2'b01;
    localparam logic [1:0] OUTSEL_Q    = 2'b10;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/booth_sequencer_counter.sv
// Iteration counter for the Booth sequencer. Cleared at the start of an
// operation, advanced once per non-final shift; term flags the last iteration.
module iter_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    // Count register: clear has priority over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_sequencer.sv
// Radix-2 Booth multiplication control unit. Sequences clear/load/add/sub/shift
// commands for the A, Q, M registers and then drives the product onto the
// outbus in two beats (A, then Q), finishing with a one-cycle done pulse.
module booth_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       q0,
    input  logic       q_m1,
    output logic       busy,
    output logic       load_m,
    output logic       load_q,
    output logic       clr_a,
    output logic       load_a,
    output logic       add_sub,
    output logic       shift_r,
    output logic [1:0] out_sel,
    output logic       done
);

    state_t           state;
    state_t           state_next;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_term;
    logic [CNT_W-1:0] cnt;

    iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt),
        .term  (cnt_term)
    );

    // State register; async reset drops straight to IDLE so all controls go low at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and control decode; ADD is the only state that looks at Q[0]/Q[-1].
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        load_m     = 1'b0;
        load_q     = 1'b0;
        clr_a      = 1'b0;
        load_a     = 1'b0;
        add_sub    = OP_ADD;
        shift_r    = 1'b0;
        out_sel    = OUTSEL_NONE;
        done       = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_m     = 1'b1;
                load_q     = 1'b1;
                clr_a      = 1'b1;
                cnt_clr    = 1'b1;
                state_next = ST_ADD;
            end
            ST_ADD: begin
                // 10 starts a run of ones (subtract M), 01 ends one (add M).
                case ({q0, q_m1})
                    2'b10: begin
                        load_a  = 1'b1;
                        add_sub = OP_SUB;
                    end
                    2'b01: begin
                        load_a  = 1'b1;
                        add_sub = OP_ADD;
                    end
                    default: begin
                        load_a  = 1'b0;
                        add_sub = OP_ADD;
                    end
                endcase
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_r = 1'b1;
                if (cnt_term) begin
                    state_next = ST_OUT_A;
                end else begin
                    cnt_inc    = 1'b1;
                    state_next = ST_ADD;
                end
            end
            ST_OUT_A: begin
                out_sel    = OUTSEL_A;
                state_next = ST_OUT_Q;
            end
            ST_OUT_Q: begin
                out_sel    = OUTSEL_Q;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // The count value itself is only consumed through term.
    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule
